// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, command opcodes and the CSR master state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_AR,
    ST_RD,
    ST_GAP,
    ST_RSP
  } state_e;

endpackage

// File: rtl/axil_csr_master.sv
// AXI4-Lite initiator turning a one-outstanding command/response handshake into CSR writes,
// reads and read-poll-until-match sequences, with a sticky stall timeout flag.
module axil_csr_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int POLL_GAP       = 16,
  parameter int POLL_MAX       = 1024,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_poll_fail,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  // One timer serves both the stall timeout and the poll gap, so it must cover the larger.
  localparam int TIMER_MAX = (TIMEOUT_CYCLES > POLL_GAP) ? TIMEOUT_CYCLES : POLL_GAP;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [TW-1:0] TIMER_SAT = '1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  state_e                state_reg, state_next;
  cmd_op_e               op_reg, op_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0] wstrb_reg, wstrb_next;
  logic [DATA_WIDTH-1:0] mask_reg, mask_next;
  logic                  awvalid_reg, awvalid_next;
  logic                  wvalid_reg, wvalid_next;
  logic                  arvalid_reg, arvalid_next;
  logic                  bready_reg, bready_next;
  logic                  rready_reg, rready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]            rsp_resp_reg, rsp_resp_next;
  logic                  poll_fail_reg, poll_fail_next;
  logic                  timeout_reg, timeout_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [PW-1:0]         polls_reg, polls_next;

  logic aw_hs, w_hs, waiting;

  assign aw_hs   = awvalid_reg & m_axi_awready;
  assign w_hs    = wvalid_reg & m_axi_wready;
  assign waiting = (state_reg == ST_WR) || (state_reg == ST_WB) ||
                   (state_reg == ST_AR) || (state_reg == ST_RD);

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    mask_next      = mask_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    bready_next    = 1'b0;
    rready_next    = 1'b0;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    poll_fail_next = poll_fail_reg;
    polls_next     = polls_reg;
    timeout_next   = timeout_reg;
    timer_next     = (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (cmd_valid) begin
          op_next        = cmd_op_e'(cmd_op);
          addr_next      = cmd_addr;
          wdata_next     = cmd_wdata;
          wstrb_next     = cmd_wstrb;
          mask_next      = cmd_mask;
          rsp_rdata_next = '0;
          rsp_resp_next  = RESP_OKAY;
          poll_fail_next = 1'b0;
          polls_next     = '0;
          case (cmd_op_e'(cmd_op))
            OP_WRITE: begin
              awvalid_next = 1'b1;
              wvalid_next  = 1'b1;
              state_next   = ST_WR;
            end
            OP_READ, OP_POLL: begin
              arvalid_next = 1'b1;
              polls_next   = PW'(1);
              state_next   = ST_AR;
            end
            default: begin
              rsp_resp_next  = RESP_SLVERR;
              rsp_valid_next = 1'b1;
              state_next     = ST_RSP;
            end
          endcase
        end
      end
      ST_WR: begin
        if (aw_hs) begin
          awvalid_next = 1'b0;
          timer_next   = '0;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
          timer_next  = '0;
        end
        // AW and W may complete in either order; B is only awaited once both are gone.
        if ((aw_hs || !awvalid_reg) && (w_hs || !wvalid_reg)) begin
          bready_next = 1'b1;
          state_next  = ST_WB;
        end
      end
      ST_WB: begin
        bready_next = 1'b1;
        if (bready_reg && m_axi_bvalid) begin
          bready_next    = 1'b0;
          rsp_resp_next  = m_axi_bresp;
          rsp_valid_next = 1'b1;
          timer_next     = '0;
          state_next     = ST_RSP;
        end
      end
      ST_AR: begin
        if (arvalid_reg && m_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          timer_next   = '0;
          state_next   = ST_RD;
        end
      end
      ST_RD: begin
        rready_next = 1'b1;
        if (rready_reg && m_axi_rvalid) begin
          rready_next    = 1'b0;
          rsp_rdata_next = m_axi_rdata;
          rsp_resp_next  = m_axi_rresp;
          timer_next     = '0;
          if (op_reg != OP_POLL || m_axi_rresp != RESP_OKAY ||
              ((m_axi_rdata ^ wdata_reg) & mask_reg) == '0) begin
            rsp_valid_next = 1'b1;
            state_next     = ST_RSP;
          end else if (polls_reg == POLL_LAST) begin
            poll_fail_next = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = ST_RSP;
          end else begin
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (timer_reg == GAP_LAST) begin
          arvalid_next = 1'b1;
          polls_next   = polls_reg + 1'b1;
          timer_next   = '0;
          state_next   = ST_AR;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (waiting && timer_reg >= TO_LAST) timeout_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_WRITE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      mask_reg      <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
      poll_fail_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      timer_reg     <= '0;
      polls_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      mask_reg      <= mask_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      arvalid_reg   <= arvalid_next;
      bready_reg    <= bready_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
      poll_fail_reg <= poll_fail_next;
      timeout_reg   <= timeout_next;
      timer_reg     <= timer_next;
      polls_reg     <= polls_next;
    end
  end

  assign cmd_ready     = (state_reg == ST_IDLE);
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign rsp_poll_fail = poll_fail_reg;
  assign timeout       = timeout_reg;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_axil_csr_master.sv
// Bench for axil_csr_master: behavioural CSR slave with per-channel stalls, table-driven commands,
// a response scoreboard and hand-written latency, stall, poll, timeout and reset sequences.
module tb_axil_csr_master;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_poll_fail;
  logic          timeout;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  axil_csr_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_GAP(16), .POLL_MAX(4), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_poll_fail(rsp_poll_fail), .timeout(timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- behavioural CSR slave ----------------
  int aw_stall = 0, w_stall = 0, ar_stall = 0, b_stall = 0, poll_base = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0;
  int cyc = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, w_only = 0, stab_err = 0;
  int ar_times[$];
  logic [DW-1:0] mem [64];
  logic          got_aw = 1'b0, got_w = 1'b0, b_pend = 1'b0;
  logic [AW-1:0] aw_l;
  logic [DW-1:0] wd_l;
  logic [3:0]    ws_l;
  logic          prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;
  logic          prev_arv = 1'b0, prev_arr = 1'b0;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;
  logic [3:0]    prev_wstrb;
  logic          aw_hs, w_hs, complete;
  logic [AW-1:0] a_c;
  logic [DW-1:0] d_c;
  logic [3:0]    s_c;
  logic          bv_r = 1'b0, rv_r = 1'b0;
  logic [1:0]    bresp_r = 2'b00, rresp_r = 2'b00;
  logic [DW-1:0] rdata_r = '0;

  initial for (int i = 0; i < 64; i++) mem[i] = '0;

  assign awready = (aw_wait >= aw_stall);
  assign wready  = (w_wait >= w_stall);
  assign arready = (ar_wait >= ar_stall);
  assign bvalid  = bv_r;
  assign bresp   = bresp_r;
  assign rvalid  = rv_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; bv_r <= 1'b0; rv_r <= 1'b0;
      prev_awv <= 1'b0; prev_wv <= 1'b0; prev_arv <= 1'b0;
    end else begin
      if ((prev_awv && !prev_awr && (!awvalid || awaddr !== prev_awaddr)) ||
          (prev_wv && !prev_wr && (!wvalid || wdata !== prev_wdata || wstrb !== prev_wstrb)) ||
          (prev_arv && !prev_arr && (!arvalid || araddr !== prev_araddr)))
        stab_err <= stab_err + 1;
      if (!awvalid && wvalid) w_only <= w_only + 1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (aw_hs) begin aw_cnt <= aw_cnt + 1; got_aw <= 1'b1; aw_l <= awaddr; aw_wait <= 0; end
      else if (awvalid) aw_wait <= aw_wait + 1;
      if (w_hs) begin w_cnt <= w_cnt + 1; got_w <= 1'b1; wd_l <= wdata; ws_l <= wstrb; w_wait <= 0; end
      else if (wvalid) w_wait <= w_wait + 1;
      complete = (got_aw || aw_hs) && (got_w || w_hs);
      if (complete) begin
        a_c = got_aw ? aw_l : awaddr;
        d_c = got_w ? wd_l : wdata;
        s_c = got_w ? ws_l : wstrb;
        got_aw <= 1'b0; got_w <= 1'b0;
        if (a_c >= 12'h080) bresp_r <= SLVERR;
        else begin
          bresp_r <= OKAY;
          for (int i = 0; i < 4; i++) if (s_c[i]) mem[a_c[7:2]][8*i +: 8] <= d_c[8*i +: 8];
        end
        if (b_stall == 0) bv_r <= 1'b1;
        else begin b_pend <= 1'b1; b_wait <= 1; end
      end
      if (b_pend) begin
        if (b_wait >= b_stall) begin bv_r <= 1'b1; b_pend <= 1'b0; end
        else b_wait <= b_wait + 1;
      end
      if (bv_r && bready) begin bv_r <= 1'b0; b_cnt <= b_cnt + 1; end
      if (arvalid && arready) begin
        ar_cnt <= ar_cnt + 1;
        ar_times.push_back(cyc);
        ar_wait <= 0;
        rv_r <= 1'b1;
        if (araddr >= 12'h080) begin rdata_r <= '0; rresp_r <= SLVERR; end
        else if (araddr == 12'h020) begin
          rdata_r <= (ar_cnt + 1 - poll_base >= 3) ? 32'h1 : 32'h0; rresp_r <= OKAY;
        end else begin rdata_r <= mem[araddr[7:2]]; rresp_r <= OKAY; end
      end else if (arvalid) ar_wait <= ar_wait + 1;
      if (rv_r && rready) rv_r <= 1'b0;
      prev_awv <= awvalid; prev_awr <= awready; prev_awaddr <= awaddr;
      prev_wv <= wvalid; prev_wr <= wready; prev_wdata <= wdata; prev_wstrb <= wstrb;
      prev_arv <= arvalid; prev_arr <= arready; prev_araddr <= araddr;
    end
  end

  // ---------------- scoreboard and command driver ----------------
  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] mask;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_fail;
    int          exp_beats;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        fail;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                              input logic [3:0] strb, input logic [31:0] mask, input logic [31:0] erd,
                              input logic [1:0] ersp, input logic efail, input int beats);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.strb = strb; v.mask = mask;
    v.exp_rdata = erd; v.exp_resp = ersp; v.exp_fail = efail; v.exp_beats = beats;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v, input int hold, output int lat);
    exp_t e;
    int n, acc;
    logic [31:0] r0;
    logic [1:0] p0;
    logic unstable;
    e.rdata = v.exp_rdata; e.resp = v.exp_resp; e.fail = v.exp_fail;
    exp_q.push_back(e);
    lat = -1;
    @(negedge clk);
    cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb; cmd_mask = v.mask;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_accept", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20000) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      check("rsp_wait", rsp_valid, 1'b1);
      void'(exp_q.pop_front());
      return;
    end
    lat = cyc - acc;
    r0 = rsp_rdata; p0 = rsp_resp; unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_resp !== p0) unstable = 1'b1;
    end
    if (hold > 0) check("rsp_hold_stable", unstable, 1'b0);
    e = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_resp", rsp_resp, e.resp);
    check("rsp_poll_fail", rsp_poll_fail, e.fail);
    $display("txn op=%b addr=%h rdata=%h resp=%b poll_fail=%b lat=%0d",
             v.op, v.addr, rsp_rdata, rsp_resp, rsp_poll_fail, lat);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop_cmd_ready", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  vec_t tbl[10];
  int lat, b0, a0, w0, r0, wo0, n;

  initial begin
    tbl[0] = mk(2'b00, 12'h004, 32'h0000_0003, 4'hF, '0, '0, OKAY, 1'b0, 2);
    tbl[1] = mk(2'b01, 12'h004, '0, 4'h0, '0, 32'h0000_0003, OKAY, 1'b0, 1);
    tbl[2] = mk(2'b00, 12'h010, 32'hDEAD_BEEF, 4'hF, '0, '0, OKAY, 1'b0, 2);
    tbl[3] = mk(2'b00, 12'h008, 32'hAABB_CCDD, 4'b0101, '0, '0, OKAY, 1'b0, 2);
    tbl[4] = mk(2'b01, 12'h008, '0, 4'h0, '0, 32'h00BB_00DD, OKAY, 1'b0, 1);
    tbl[5] = mk(2'b11, 12'h004, 32'h1234_5678, 4'hF, '0, '0, SLVERR, 1'b0, 0);
    tbl[6] = mk(2'b01, 12'h080, '0, 4'h0, '0, '0, SLVERR, 1'b0, 1);
    tbl[7] = mk(2'b00, 12'h084, 32'h5555_5555, 4'hF, '0, '0, SLVERR, 1'b0, 2);
    tbl[8] = mk(2'b10, 12'h004, 32'h0000_0003, 4'h0, 32'h0000_0003, 32'h0000_0003, OKAY, 1'b0, 1);
    tbl[9] = mk(2'b10, 12'h008, 32'h00BB_0000, 4'h0, 32'hFFFF_0000, 32'h00BB_00DD, OKAY, 1'b0, 1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("reset_rsp", {rsp_valid, rsp_resp, rsp_poll_fail}, 4'b0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_timeout", timeout, 1'b0);
    check("reset_awaddr", awaddr, 32'h0);
    check("reset_wdata", wdata, 32'h0);

    for (int i = 0; i < 10; i++) begin
      b0 = aw_cnt + w_cnt + ar_cnt;
      run_cmd(tbl[i], i % 3, lat);
      check($sformatf("beats_row%0d", i), aw_cnt + w_cnt + ar_cnt - b0, tbl[i].exp_beats);
    end

    // Back-to-back write with an always-ready slave: fixed 3-cycle response latency.
    a0 = aw_cnt; w0 = w_cnt;
    run_cmd(mk(2'b00, 12'h004, 32'h0000_0003, 4'hF, '0, '0, OKAY, 1'b0, 2), 0, lat);
    check("write_latency", lat, 3);
    check("write_one_aw", aw_cnt - a0, 1);
    check("write_one_w", w_cnt - w0, 1);

    // AW accepted well before W: awvalid must drop alone while wvalid holds.
    w_stall = 5; wo0 = w_only; b0 = b_cnt;
    run_cmd(mk(2'b00, 12'h00C, 32'h1234_5678, 4'hF, '0, '0, OKAY, 1'b0, 2), 0, lat);
    w_stall = 0;
    check("w_holds_after_aw", (w_only - wo0) >= 4, 1'b1);
    check("single_b", b_cnt - b0, 1);
    run_cmd(mk(2'b01, 12'h00C, '0, 4'h0, '0, 32'h1234_5678, OKAY, 1'b0, 1), 0, lat);

    // Read with the response held back by rsp_ready.
    run_cmd(mk(2'b01, 12'h010, '0, 4'h0, '0, 32'hDEAD_BEEF, OKAY, 1'b0, 1), 4, lat);

    // Poll that matches on the third read.
    poll_base = ar_cnt; r0 = ar_cnt;
    run_cmd(mk(2'b10, 12'h020, 32'h1, 4'h0, 32'h1, 32'h1, OKAY, 1'b0, 3), 0, lat);
    check("poll_ar_beats", ar_cnt - r0, 3);
    n = ar_times.size();
    if (n >= 3) begin
      check("poll_gap_1", (ar_times[n-2] - ar_times[n-3]) >= 16, 1'b1);
      check("poll_gap_2", (ar_times[n-1] - ar_times[n-2]) >= 16, 1'b1);
    end else check("poll_ar_log", n, 3);

    // Poll that never matches: exhausts POLL_MAX reads.
    r0 = ar_cnt;
    run_cmd(mk(2'b10, 12'h024, 32'h1, 4'h0, 32'h1, 32'h0, OKAY, 1'b1, 4), 0, lat);
    check("poll_max_reads", ar_cnt - r0, 4);

    // Long arready stall raises the sticky timeout; the read still completes.
    check("timeout_before_stall", timeout, 1'b0);
    ar_stall = 5000;
    run_cmd(mk(2'b01, 12'h004, '0, 4'h0, '0, 32'h3, OKAY, 1'b0, 1), 0, lat);
    ar_stall = 0;
    check("timeout_set", timeout, 1'b1);
    run_cmd(mk(2'b01, 12'h004, '0, 4'h0, '0, 32'h3, OKAY, 1'b0, 1), 0, lat);
    check("timeout_sticky", timeout, 1'b1);

    // Reset while waiting on B.
    b_stall = 50;
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 12'h030; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 100) begin @(negedge clk); n++; end
    check("reached_wb", bready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b_stall = 0;
    check("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    check("rst_mid_cmd_ready", cmd_ready, 1'b1);
    check("rst_clears_timeout", timeout, 1'b0);
    run_cmd(mk(2'b01, 12'h004, '0, 4'h0, '0, 32'h3, OKAY, 1'b0, 1), 0, lat);

    check("axi_stability", stab_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
